// File: rtl/ai_paddle_tracker_if.sv
// Signal bundle between the ball-physics block, the computer-opponent paddle and the renderer.
// The master modport belongs to the paddle tracker.
interface ai_paddle_tracker_if #(
  parameter int POS_W = 10
);
  logic [POS_W-1:0] ball_v;
  logic [1:0]       mode;
  logic [POS_W-1:0] paddle_h;
  logic [POS_W-1:0] paddle_v;
  logic             moving_up;
  logic             moving_dn;
  logic             tick;

  modport master (
    input  ball_v, mode,
    output paddle_h, paddle_v, moving_up, moving_dn, tick
  );

  modport slave (
    output ball_v, mode,
    input  paddle_h, paddle_v, moving_up, moving_dn, tick
  );
endinterface

// File: rtl/ai_paddle_tracker.sv
// Computer-opponent paddle: steps one paddle toward a live or delayed copy of the ball
// once per movement tick, clamped to the playfield, with a homing mode and a freeze mode.
module ai_paddle_tracker #(
  parameter int POS_W       = 10,
  parameter int DELAY_DEPTH = 8,
  parameter int TICK_DIV    = 1048576,
  parameter int STEP        = 3,
  parameter int DEADBAND    = 2,
  parameter int PADDLE_H    = 80,
  parameter int PADDLE_X    = 620,
  parameter int TOP_BOUND   = 10,
  parameter int BOT_BOUND   = 470,
  parameter int HOME_V      = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  ai_paddle_tracker_if.master   bus
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int FILL_W = $clog2(DELAY_DEPTH + 1);
  localparam int W      = POS_W + 2;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(DELAY_DEPTH);
  localparam logic [POS_W-1:0]    HOME_P   = POS_W'(HOME_V);
  localparam logic [POS_W-1:0]    TOP_P    = POS_W'(TOP_BOUND);
  localparam logic [POS_W-1:0]    MAXV_P   = POS_W'(BOT_BOUND - PADDLE_H);
  localparam logic signed [W-1:0] HALF_S   = W'(PADDLE_H / 2);
  localparam logic signed [W-1:0] DB_S     = W'(DEADBAND);
  localparam logic signed [W-1:0] STEP_S   = W'(STEP);
  localparam logic signed [W-1:0] TOP_S    = W'(TOP_BOUND);
  localparam logic signed [W-1:0] MAXV_S   = W'(BOT_BOUND - PADDLE_H);
  localparam logic signed [W-1:0] HOME_S   = W'(HOME_V);
  localparam logic signed [W-1:0] HOME_C_S = W'(HOME_V + PADDLE_H / 2);

  typedef enum logic [1:0] {
    S_HOLD,
    S_TRACK,
    S_RETURN
  } state_t;

  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic [POS_W-1:0]    line [DELAY_DEPTH];
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   fill_after;
  logic                fill_ready;
  state_t              state;
  state_t              state_next;
  logic [POS_W-1:0]    pv;
  logic [POS_W-1:0]    pv_next;
  logic                up_q;
  logic                dn_q;
  logic signed [W-1:0] pv_s;
  logic signed [W-1:0] centre_s;
  logic signed [W-1:0] target_s;
  logic signed [W-1:0] step_up_s;
  logic signed [W-1:0] step_dn_s;
  logic signed [W-1:0] gap_s;
  logic signed [W-1:0] ret_step_s;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The delay line keeps filling in every mode so a return to delayed tracking needs no refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DELAY_DEPTH; i++) begin
        line[i] <= '0;
      end
      fill <= '0;
    end else if (tick) begin
      line[0] <= bus.ball_v;
      for (int i = 1; i < DELAY_DEPTH; i++) begin
        line[i] <= line[i-1];
      end
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  assign fill_after = (fill == FILL_MAX) ? fill : fill + 1'b1;
  assign fill_ready = (fill_after == FILL_MAX);

  always_comb begin
    state_next = state;
    if (bus.mode == 2'b11) begin
      state_next = S_HOLD;
    end else begin
      case (state)
        S_HOLD: begin
          if ((bus.mode == 2'b01 && fill_ready) || bus.mode == 2'b10) begin
            state_next = S_TRACK;
          end else if (bus.mode == 2'b00) begin
            state_next = S_RETURN;
          end
        end
        S_TRACK: begin
          if (bus.mode == 2'b00) begin
            state_next = S_RETURN;
          end
        end
        S_RETURN: begin
          if (bus.mode == 2'b00 && pv == HOME_P) begin
            state_next = S_HOLD;
          end else if ((bus.mode == 2'b01 && fill_ready) || bus.mode == 2'b10) begin
            state_next = S_TRACK;
          end
        end
        default: state_next = S_HOLD;
      endcase
    end
  end

  // Signed arithmetic two bits wider than the bus so neither sums nor differences can wrap.
  always_comb begin
    pv_s       = $signed({2'b00, pv});
    centre_s   = pv_s + HALF_S;
    step_up_s  = pv_s + STEP_S;
    step_dn_s  = pv_s - STEP_S;
    gap_s      = (pv_s > HOME_S) ? (pv_s - HOME_S) : (HOME_S - pv_s);
    ret_step_s = (gap_s < STEP_S) ? gap_s : STEP_S;
    case (bus.mode)
      2'b01:   target_s = $signed({2'b00, line[DELAY_DEPTH-1]});
      2'b10:   target_s = $signed({2'b00, bus.ball_v});
      default: target_s = HOME_C_S;
    endcase
  end

  always_comb begin
    pv_next = pv;
    if (bus.mode != 2'b11) begin
      if (state == S_TRACK) begin
        if (target_s > centre_s + DB_S) begin
          pv_next = (step_up_s > MAXV_S) ? MAXV_P : POS_W'(step_up_s);
        end else if (target_s < centre_s - DB_S) begin
          pv_next = (step_dn_s < TOP_S) ? TOP_P : POS_W'(step_dn_s);
        end
      end else if (state == S_RETURN) begin
        if (pv_s > HOME_S) begin
          pv_next = POS_W'(pv_s - ret_step_s);
        end else if (pv_s < HOME_S) begin
          pv_next = POS_W'(pv_s + ret_step_s);
        end
      end
    end
  end

  // Direction flags compare old and new position, so a clamped step reports no movement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_HOLD;
      pv    <= HOME_P;
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
    end else if (tick) begin
      state <= state_next;
      pv    <= pv_next;
      up_q  <= (pv_next < pv);
      dn_q  <= (pv_next > pv);
    end
  end

  assign bus.paddle_h  = POS_W'(PADDLE_X);
  assign bus.paddle_v  = pv;
  assign bus.moving_up = up_q;
  assign bus.moving_dn = dn_q;
  assign bus.tick      = tick;

endmodule
